mux4_rr_arbiter: RTL and testbench

- Round-robin controller sharing the 4:1 single-bit mux datapath (data D0..D3, selects A/B, output Y) among four requesters.
- Requester i owns data bit D[i]. The block arbitrates requests, drives the mux selects {A,B}, and registers the selected bit onto Y.
- Sits between the four requesters and the mux; also serves as the bench driver replacing hand-stepped select sweeps.

---
 rtl/mux4_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 single-bit mux, with registered output Y.
// Define MUX_ARB_TIMEOUT_EN to let a waiting requester preempt an owner held for MAX_HOLD cycles.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] D,
    output logic [3:0] gnt,
    output logic       A,
    output logic       B,
    output logic       Y,
    output logic       busy
);

`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             r_state;
    logic [3:0]         r_gnt;
    logic [1:0]         r_sel;
    logic [1:0]         r_last;
    logic               r_y;
    logic               r_busy;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic [3:0]         w_others;
    logic [1:0]         w_pick_idle;
    logic [1:0]         w_pick_next;
    logic               w_hold_max;
    logic               w_hold_sat;
    logic               w_do_grant;
    logic               w_go_idle;
    logic               w_hold_clr;
    logic [1:0]         w_win;

    // First set bit of vec searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] vec);
        logic [1:0] idx;
        logic [1:0] step;
        rr_pick = ptr;
        for (int unsigned k = 4; k >= 1; k--) begin
            step = k[1:0];
            idx  = ptr + step;
            if (vec[idx]) rr_pick = idx;
        end
    endfunction

    assign w_others    = req & ~r_gnt;
    assign w_pick_idle = rr_pick(r_last, req);
    assign w_pick_next = rr_pick(r_sel, w_others);
    assign w_hold_max  = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_hold_sat  = &r_hold_cnt;

    always_comb begin
        w_do_grant = 1'b0;
        w_go_idle  = 1'b0;
        w_hold_clr = 1'b0;
        w_win      = w_pick_next;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_do_grant = 1'b1;
                    w_win      = w_pick_idle;
                end
            end
            S_GRANT: begin
                // Release takes precedence over a coincident timeout.
                if (!req[r_sel]) begin
                    if (|w_others) w_do_grant = 1'b1;
                    else           w_go_idle  = 1'b1;
                end else if (TIMEOUT_EN && w_hold_max) begin
                    if (|w_others) w_do_grant = 1'b1;
                    else           w_hold_clr = 1'b1;
                end
            end
            default: w_go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_last     <= 2'd3;
            r_y        <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_y <= D[r_sel];
            if (w_do_grant) begin
                r_state    <= S_GRANT;
                r_gnt      <= 4'b0001 << w_win;
                r_sel      <= w_win;
                r_last     <= w_win;
                r_busy     <= 1'b1;
                r_hold_cnt <= '0;
            end else if (w_go_idle) begin
                r_state    <= S_IDLE;
                r_gnt      <= '0;
                r_busy     <= 1'b0;
                r_hold_cnt <= '0;
            end else if (r_state == S_GRANT) begin
                if (w_hold_clr)       r_hold_cnt <= '0;
                else if (!w_hold_sat) r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign gnt  = r_gnt;
    assign A    = r_sel[1];
    assign B    = r_sel[0];
    assign Y    = r_y;
    assign busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: behavioural model compared every cycle plus directed literal checks.
module tb_mux4_rr_arbiter;

    localparam int MAXH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] D = '0;
    logic [3:0] gnt;
    logic       A, B, Y, busy;

    int checks = 0;
    int failures = 0;

    // Model: owner index or -1 when idle, last winner, select, hold count, Y.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_y     = 1'b0;

    mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .D(D),
        .gnt(gnt), .A(A), .B(B), .Y(Y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input int p, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0; m_y = 1'b0;
    endtask

    task automatic model_take(input int w);
        m_owner = w; m_last = w; m_sel = w; m_hold = 0;
    endtask

    task automatic model_step();
        logic [3:0] one;
        logic [3:0] others;
        bit         ny;
        ny = D[m_sel];
        if (m_owner < 0) begin
            if (req != 0) model_take(search(m_last, req));
        end else begin
            one    = 4'b0001 << m_owner;
            others = req & ~one;
            if (!req[m_owner]) begin
                if (others != 0) model_take(search(m_owner, others));
                else begin m_owner = -1; m_hold = 0; end
            end else if (TO && m_hold == MAXH - 1) begin
                if (others != 0) model_take(search(m_owner, others));
                else m_hold = 0;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
        m_y = ny;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        logic [3:0] eg;
        if (!rst_n) model_reset();
        else model_step();
        #1;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check("model_gnt", gnt, eg);
        check("model_sel", {A, B}, m_sel);
        check("model_y", Y, m_y);
        check("model_busy", busy, m_owner >= 0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit         exp_y [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset then idle
        D = 4'b0000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_gnt", gnt, 4'b0000);
            check("idle_ab", {A, B}, 2'b00);
            check("idle_y", Y, 1'b0);
            check("idle_busy", busy, 1'b0);
        end

        // Single request
        @(negedge clk);
        D = 4'b1010;
        req = 4'b0010;
        @(posedge clk); #1;
        check("single_gnt", gnt, 4'b0010);
        check("single_ab", {A, B}, 2'b01);
        check("single_busy", busy, 1'b1);
        @(posedge clk); #1;
        check("single_y", Y, 1'b1);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        check("drop_gnt", gnt, 4'b0000);
        check("drop_busy", busy, 1'b0);
        check("drop_ab", {A, B}, 2'b01);

        // Round-robin fairness
        do_reset();
        D = 4'b1010;
        @(negedge clk);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk); #1;
            check("rr_gnt", gnt, exp_g[g]);
            check("rr_busy", busy, 1'b1);
            @(negedge clk);
            req = 4'b1111;
            @(posedge clk); #1;
            check("rr_y", Y, exp_y[g]);
            @(negedge clk);
            req = 4'b1111 & ~exp_g[g];
        end
        @(negedge clk);
        req = 4'b0000;

        // Timeout / no-timeout
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk); #1;
        check("to_start", gnt, 4'b0001);
        @(negedge clk);
        req = 4'b0101;
`ifdef MUX_ARB_TIMEOUT_EN
        repeat (3) begin
            @(posedge clk); #1;
            check("to_hold", gnt, 4'b0001);
        end
        @(posedge clk); #1;
        check("to_preempt", gnt, 4'b0100);
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        repeat (14) begin
            @(posedge clk); #1;
            check("to_alone", gnt, 4'b0001);
        end
`else
        repeat (20) begin
            @(posedge clk); #1;
            check("nto_hold", gnt, 4'b0001);
        end
        @(negedge clk);
        req = 4'b0100;
        @(posedge clk); #1;
        check("nto_switch", gnt, 4'b0100);
`endif

        // Async reset mid-grant
        do_reset();
        D = 4'b1111;
        @(negedge clk);
        req = 4'b1000;
        @(posedge clk); #1;
        check("ar_gnt", gnt, 4'b1000);
        @(posedge clk); #1;
        check("ar_y_pre", Y, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_gnt0", gnt, 4'b0000);
        check("ar_ab0", {A, B}, 2'b00);
        check("ar_y0", Y, 1'b0);
        check("ar_busy0", busy, 1'b0);
        #1 rst_n = 1'b1;
        req = 4'b1111;
        @(posedge clk); #1;
        check("ar_first", gnt, 4'b0001);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            D = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
